chunk_sum_accumulator: RTL and testbench

//  Upstream feeder for the 43-bit + zero-extended 19-bit adder stage.

---
 rtl/chunk_sum_accumulator_if.sv | 28 ++
 rtl/chunk_sum_accumulator.sv | 115 +++++++++++
 tb/tb_chunk_sum_accumulator.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/chunk_sum_accumulator_if.sv
// Stream bundle for the chunk accumulator: chunk input channel plus result output channel.
interface chunk_sum_accumulator_if #(
  parameter int unsigned ACC_W = 43,
  parameter int unsigned IN_W  = 19,
  parameter int unsigned CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  // Upstream/downstream environment view: drives chunks, consumes results.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  // Accumulator view: accepts chunks, produces results.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/chunk_sum_accumulator.sv
// Folds a valid/ready stream of unsigned chunks into a saturating running sum and
// presents sum, beat count and sticky overflow on a registered result channel.
module chunk_sum_accumulator #(
  parameter int unsigned ACC_W      = 43,
  parameter int unsigned IN_W       = 19,
  parameter int unsigned MAX_CHUNKS = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  chunk_sum_accumulator_if.slave    bus
);

  localparam int unsigned PAD_W = ACC_W - IN_W;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             ready_q, ready_d;

  logic             accept;
  logic [ACC_W:0]   sum_w;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_max;

  // Ready comes from a register so it is low through reset and never sees the data path.
  assign bus.in_ready  = ready_q && !clear;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign sum_w   = {1'b0, acc_q} + {{(PAD_W + 1){1'b0}}, bus.in_data};
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign at_max  = (cnt_inc == CNT_W'(MAX_CHUNKS));

  // Next-state logic: clear overrides handshakes; saturation is sticky within a packet.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = {{PAD_W{1'b0}}, bus.in_data};
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = (bus.in_last || MAX_CHUNKS == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (sum_w[ACC_W] || ovf_q) begin
              acc_d = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum_w[ACC_W-1:0];
            end
            cnt_d   = cnt_inc;
            state_d = (bus.in_last || at_max) ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
    out_valid_d = (state_d == HOLD);
    ready_d     = (state_d != HOLD);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
    end
  end

endmodule

// File: tb/tb_chunk_sum_accumulator.sv
// Directed bench for chunk_sum_accumulator: a default-width instance and an ACC_W=20
// instance share identical stimulus so the narrow one exposes saturation.
module tb_chunk_sum_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [18:0] in_data;
  logic        in_last;
  logic        out_ready;

  int n_checks;
  int n_fail;

  chunk_sum_accumulator_if #(.ACC_W(43), .IN_W(19), .CNT_W(5)) bus_a ();
  chunk_sum_accumulator_if #(.ACC_W(20), .IN_W(19), .CNT_W(5)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.in_last   = in_last;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.in_last   = in_last;
  assign bus_b.out_ready = out_ready;

  chunk_sum_accumulator #(.ACC_W(43), .IN_W(19), .MAX_CHUNKS(16), .CNT_W(5)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus_a.slave)
  );

  chunk_sum_accumulator #(.ACC_W(20), .IN_W(19), .MAX_CHUNKS(16), .CNT_W(5)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus_b.slave)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one beat and holds it until accepted; entered and left just after a rising edge.
  task automatic applyStimulus(input logic [18:0] data, input logic last);
    bit taken;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    taken    = 1'b0;
    for (int i = 0; i < 20 && !taken; i++) begin
      @(negedge clk);
      if (bus_a.in_ready) taken = 1'b1;
      else if (i < 19) begin
        @(posedge clk);
        #1;
      end
    end
    if (!taken) checkOutput("beat_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("rst_out_sum",   64'(bus_a.out_sum),   64'd0);
    checkOutput("rst_out_count", 64'(bus_a.out_count), 64'd0);
    checkOutput("rst_out_ovf",   64'(bus_a.out_ovf),   64'd0);
    checkOutput("rst_in_ready",  64'(bus_a.in_ready),  64'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("post_rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    nextCycle();

    // Basic three-beat packet.
    $display("[TB] basic packet");
    out_ready = 1'b1;
    applyStimulus(19'h7FFFF, 1'b0);
    applyStimulus(19'h7FFFF, 1'b0);
    applyStimulus(19'h7FFFF, 1'b1);
    @(negedge clk);
    checkOutput("basic_valid", 64'(bus_a.out_valid), 64'd1);
    checkOutput("basic_sum",   64'(bus_a.out_sum),   64'h17FFFD);
    checkOutput("basic_count", 64'(bus_a.out_count), 64'd3);
    checkOutput("basic_ovf",   64'(bus_a.out_ovf),   64'd0);
    checkOutput("basic_narrow_sum", 64'(bus_b.out_sum), 64'hFFFFF);
    checkOutput("basic_narrow_ovf", 64'(bus_b.out_ovf), 64'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("basic_drained", 64'(bus_a.out_valid), 64'd0);
    nextCycle();

    // Forced close at sixteen beats.
    $display("[TB] forced close");
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) applyStimulus(19'h00001, 1'b0);
    @(negedge clk);
    checkOutput("force_15_valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("force_15_count", 64'(bus_a.out_count), 64'd15);
    nextCycle();
    applyStimulus(19'h00001, 1'b0);
    @(negedge clk);
    checkOutput("force_valid",    64'(bus_a.out_valid), 64'd1);
    checkOutput("force_sum",      64'(bus_a.out_sum),   64'd16);
    checkOutput("force_count",    64'(bus_a.out_count), 64'd16);
    checkOutput("force_in_ready", 64'(bus_a.in_ready),  64'd0);
    nextCycle();
    out_ready = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("force_drained",  64'(bus_a.out_valid), 64'd0);
    checkOutput("force_idle_rdy", 64'(bus_a.in_ready),  64'd1);
    nextCycle();

    // Saturation on the narrow instance.
    $display("[TB] overflow");
    applyStimulus(19'h7FFFF, 1'b0);
    applyStimulus(19'h7FFFF, 1'b0);
    @(negedge clk);
    checkOutput("ovf_pre_sum", 64'(bus_b.out_sum), 64'hFFFFE);
    checkOutput("ovf_pre_ovf", 64'(bus_b.out_ovf), 64'd0);
    nextCycle();
    applyStimulus(19'h7FFFF, 1'b0);
    @(negedge clk);
    checkOutput("ovf_sat_sum", 64'(bus_b.out_sum), 64'hFFFFF);
    checkOutput("ovf_sat_ovf", 64'(bus_b.out_ovf), 64'd1);
    nextCycle();
    applyStimulus(19'h00001, 1'b1);
    @(negedge clk);
    checkOutput("ovf_valid", 64'(bus_b.out_valid), 64'd1);
    checkOutput("ovf_sum",   64'(bus_b.out_sum),   64'hFFFFF);
    checkOutput("ovf_flag",  64'(bus_b.out_ovf),   64'd1);
    checkOutput("ovf_count", 64'(bus_b.out_count), 64'd4);
    checkOutput("ovf_wide_sum", 64'(bus_a.out_sum), 64'h17FFFE);
    nextCycle();

    // Backpressure with a beat waiting upstream.
    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(19'd5, 1'b0);
    applyStimulus(19'd6, 1'b1);
    in_valid = 1'b1;
    in_data  = 19'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 64'(bus_a.in_ready),  64'd0);
      checkOutput("bp_sum",      64'(bus_a.out_sum),   64'd11);
      checkOutput("bp_valid",    64'(bus_a.out_valid), 64'd1);
      nextCycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_count", 64'(bus_a.out_count), 64'd2);
    nextCycle();
    @(negedge clk);
    checkOutput("bp_idle_valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("bp_idle_ready", 64'(bus_a.in_ready),  64'd1);
    nextCycle();

    // Clear mid-packet; the beat alongside clear is refused.
    $display("[TB] clear mid-packet");
    applyStimulus(19'd10, 1'b0);
    applyStimulus(19'd20, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 19'd30;
    @(negedge clk);
    checkOutput("clr_in_ready", 64'(bus_a.in_ready), 64'd0);
    nextCycle();
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("clr_sum",   64'(bus_a.out_sum),   64'd0);
    checkOutput("clr_count", 64'(bus_a.out_count), 64'd0);
    checkOutput("clr_valid", 64'(bus_a.out_valid), 64'd0);
    nextCycle();
    applyStimulus(19'd7, 1'b1);
    @(negedge clk);
    checkOutput("clr_next_valid", 64'(bus_a.out_valid), 64'd1);
    checkOutput("clr_next_sum",   64'(bus_a.out_sum),   64'd7);
    checkOutput("clr_next_count", 64'(bus_a.out_count), 64'd1);
    nextCycle();

    // Clear drops a held result even with out_ready high.
    $display("[TB] clear held result");
    out_ready = 1'b0;
    applyStimulus(19'd4, 1'b1);
    clear     = 1'b1;
    out_ready = 1'b1;
    nextCycle();
    clear = 1'b0;
    @(negedge clk);
    checkOutput("clr_hold_valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("clr_hold_sum",   64'(bus_a.out_sum),   64'd0);
    nextCycle();

    // Reset mid-packet.
    $display("[TB] reset mid-packet");
    applyStimulus(19'd1, 1'b0);
    applyStimulus(19'd2, 1'b0);
    rst_n = 1'b0;
    nextCycle();
    @(negedge clk);
    checkOutput("mrst_valid",    64'(bus_a.out_valid), 64'd0);
    checkOutput("mrst_sum",      64'(bus_a.out_sum),   64'd0);
    checkOutput("mrst_count",    64'(bus_a.out_count), 64'd0);
    checkOutput("mrst_ovf",      64'(bus_a.out_ovf),   64'd0);
    checkOutput("mrst_in_ready", 64'(bus_a.in_ready),  64'd0);
    rst_n = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("mrst_release_ready", 64'(bus_a.in_ready), 64'd1);
    nextCycle();
    applyStimulus(19'd3, 1'b1);
    @(negedge clk);
    checkOutput("mrst_next_valid", 64'(bus_a.out_valid), 64'd1);
    checkOutput("mrst_next_sum",   64'(bus_a.out_sum),   64'd3);
    checkOutput("mrst_next_count", 64'(bus_a.out_count), 64'd1);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
